mul_fu_controller: RTL and testbench
====================================

Name: mul_fu_controller

Overview:
- Multiply functional-unit controller for the out-of-order core.
- Shares one shift-add multiplier (start/done handshake, mul_type select) between NUM_REQ reservation-station requesters using round-robin arbitration.
- Decodes RISC-V M-extension funct3 into multiplier type and product-half selection, sequences the multiplier's start/done protocol, and returns a tagged 32-bit result to the CDB with valid/ready.
- Supports pipeline flush: in-flight work is drained and its result discarded.

Parameters:
- NUM_REQ, 2, number of requesters sharing the multiplier.
- OPERAND_WIDTH, 32, operand width; the product is 2*OPERAND_WIDTH.
- TAG_WIDTH, 5, ROB/physical-register tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill all in-flight and pending results.
- req_valid  in  NUM_REQ  request valid per requester.
- req_ready  out  NUM_REQ  request accepted (one-hot grant).
- req_funct3  in  NUM_REQ*3  funct3 per requester; only bits [1:0] are used.
- req_a  in  NUM_REQ*OPERAND_WIDTH  rs1 value per requester.
- req_b  in  NUM_REQ*OPERAND_WIDTH  rs2 value per requester.
- req_tag  in  NUM_REQ*TAG_WIDTH  destination tag per requester.
- resp_valid  out  1  result valid.
- resp_ready  in  1  CDB accepts result.
- resp_data  out  OPERAND_WIDTH  selected product half.
- resp_tag  out  TAG_WIDTH  tag of the result.
- busy  out  1  high in any state other than IDLE.
- mul_start  out  1  multiplier start.
- mul_type  out  2  0 = unsigned x unsigned, 1 = signed x signed, 2 = signed a x unsigned b.
- mul_a  out  OPERAND_WIDTH  multiplier operand a.
- mul_b  out  OPERAND_WIDTH  multiplier operand b.
- mul_p  in  2*OPERAND_WIDTH  multiplier product.
- mul_done  in  1  multiplier done.

Behaviour:
- Reset: state IDLE, rr pointer 0, kill 0. All outputs are 0: req_ready, resp_valid, resp_data, resp_tag, busy, mul_start, mul_type, mul_a, mul_b.
- rst mid-operation returns to IDLE immediately. The multiplier shares rst, so both restart clean.
- States:
  - IDLE: mul_start = 0.
  - ISSUE: mul_start = 1; operands and type held stable.
  - RESP: resp_valid = 1.
- Arbitration (IDLE and !flush only):
  - Grant the first valid requester at or after rr_ptr, searching upward with wrap-around.
  - req_ready = grant (combinational). No grant is issued in ISSUE/RESP or during flush.
- On accept:
  - Register a, b, tag, and the half select.
  - rr_ptr <= granted index + 1, wrapping to 0.
  - Next state ISSUE.
- funct3 decode (bits [1:0]):
  - 00 MUL: type 0, low half.
  - 01 MULH: type 1, high half.
  - 10 MULHSU: type 2, high half.
  - 11 MULHU: type 0, high half.
- ISSUE: hold mul_start = 1 until mul_done = 1.
  - That cycle, capture mul_p[OPERAND_WIDTH-1:0] or mul_p[2*OPERAND_WIDTH-1:OPERAND_WIDTH] into resp_data.
  - Deassert mul_start next cycle, which lets the multiplier return to its idle state.
  - Next state is RESP, or IDLE if kill is set.
- RESP: hold resp_valid, resp_data and resp_tag stable until resp_ready.
  - The handshake cycle returns to IDLE.
  - A new grant is possible in the first IDLE cycle; the multiplier is idle by then.
- Latency (OPERAND_WIDTH = 32): accept at cycle 0, mul_start from cycle 1, mul_done at cycle 66, resp_valid at cycle 67. In general, accept-to-resp_valid = 2*OPERAND_WIDTH + 3.
- Flush:
  - In IDLE: blocks the grant.
  - In ISSUE: sets kill. The multiplier cannot abort, so the controller keeps waiting for mul_done, discards the result, clears kill, and goes to IDLE. resp_valid never rises.
  - In RESP: resp_valid drops next cycle and the state goes to IDLE, even if resp_ready is also high that cycle (the CDB must not take it).
- A requester deasserting req_valid without a grant is legal; nothing is latched.
- Only one operation is in flight at a time; no buffering beyond the single result register.

Test Plan:
- Req0 MUL (funct3 000), a=7, b=6, tag=3 -> mul_type=0; resp_data=42 and resp_tag=3 at cycle 67 after accept.
- Req1 MULH, a=0xFFFFFFFD (-3), b=5 -> mul_type=1; resp_data=0xFFFFFFFF. Repeat with MULHU, a=b=0xFFFFFFFF -> resp_data=0xFFFFFFFE.
- MULHSU, a=0xFFFFFFFF, b=2 -> mul_type=2; resp_data=0xFFFFFFFF. Run with resp_ready held low 5 cycles -> resp_valid and resp_data stay stable and no new grant issues.
- Both req_valid high continuously from reset -> grants alternate 0,1,0,1. mul_start is low for at least one cycle between operations, and no operation is lost.
- Flush during ISSUE (cycle 20) -> no resp_valid; controller back to IDLE one cycle after mul_done; the next request completes correctly. Flush in the RESP cycle with resp_ready=1 -> result dropped.
- rst asserted mid-ISSUE -> all outputs 0 next cycle; a fresh MUL of 3*4 returns 12.

Source files
------------

// File: rtl/mul_fu_controller_if.sv
// Request, result and multiplier-side signals of the multiply functional-unit controller.
// The controller uses the slave view. The requesters, CDB and multiplier together use the master view.
interface mul_fu_controller_if #(
  parameter int NUM_REQ       = 2,
  parameter int OPERAND_WIDTH = 32,
  parameter int TAG_WIDTH     = 5
);
  logic                               flush;
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ*3-1:0]               req_funct3;
  logic [NUM_REQ*OPERAND_WIDTH-1:0]   req_a;
  logic [NUM_REQ*OPERAND_WIDTH-1:0]   req_b;
  logic [NUM_REQ*TAG_WIDTH-1:0]       req_tag;
  logic                               resp_valid;
  logic                               resp_ready;
  logic [OPERAND_WIDTH-1:0]           resp_data;
  logic [TAG_WIDTH-1:0]               resp_tag;
  logic                               busy;
  logic                               mul_start;
  logic [1:0]                         mul_type;
  logic [OPERAND_WIDTH-1:0]           mul_a;
  logic [OPERAND_WIDTH-1:0]           mul_b;
  logic [2*OPERAND_WIDTH-1:0]         mul_p;
  logic                               mul_done;

  modport slave (
    input  flush, req_valid, req_funct3, req_a, req_b, req_tag, resp_ready, mul_p, mul_done,
    output req_ready, resp_valid, resp_data, resp_tag, busy, mul_start, mul_type, mul_a, mul_b
  );

  modport master (
    output flush, req_valid, req_funct3, req_a, req_b, req_tag, resp_ready, mul_p, mul_done,
    input  req_ready, resp_valid, resp_data, resp_tag, busy, mul_start, mul_type, mul_a, mul_b
  );
endinterface

// File: rtl/mul_fu_controller.sv
// Multiply FU controller: round-robin arbitration over requesters, M-extension decode,
// start/done sequencing of a shared shift-add multiplier, and a tagged single-entry result.
//
// state | meaning
// IDLE  | arbitrate; grant the first valid requester at or after rr_ptr
// ISSUE | mul_start held high with stable operands until mul_done
// RESP  | resp_valid held with stable data/tag until resp_ready or flush
module mul_fu_controller #(
  parameter int NUM_REQ       = 2,
  parameter int OPERAND_WIDTH = 32,
  parameter int TAG_WIDTH     = 5
) (
  input  logic                clk,
  input  logic                rst,
  mul_fu_controller_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]               state;
  logic [PTR_W-1:0]         rr_ptr;
  logic                     kill;
  logic [OPERAND_WIDTH-1:0] a_q;
  logic [OPERAND_WIDTH-1:0] b_q;
  logic [1:0]               type_q;
  logic                     hi_q;
  logic [TAG_WIDTH-1:0]     tag_q;
  logic [OPERAND_WIDTH-1:0] data_q;

  logic                     arb_en;
  logic                     found;
  logic [NUM_REQ-1:0]       grant;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W-1:0]         cand;
  logic [PTR_W-1:0]         rr_next;
  logic [1:0]               sel_f;
  logic [1:0]               sel_type;
  logic                     sel_hi;
  logic                     drop;

  // No grant outside IDLE, while flushing, or while reset is held.
  assign arb_en = (state == IDLE) && !bus.flush && !rst;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int sum;
      sum = int'(rr_ptr) + i;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = PTR_W'(sum);
      if (arb_en && !found && bus.req_valid[cand]) begin
        found           = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = cand;
      end
    end
  end

  assign rr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // funct3[1:0]: 00 MUL lo, 01 MULH hi s*s, 10 MULHSU hi s*u, 11 MULHU hi u*u.
  assign sel_f    = bus.req_funct3[int'(grant_idx)*3 +: 2];
  assign sel_hi   = (sel_f != 2'b00);
  assign sel_type = (sel_f == 2'b01) ? 2'd1 :
                    (sel_f == 2'b10) ? 2'd2 : 2'd0;

  // A flush arriving on the done cycle itself still discards the result.
  assign drop = kill || bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      kill   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      type_q <= 2'd0;
      hi_q   <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            a_q    <= bus.req_a[int'(grant_idx)*OPERAND_WIDTH +: OPERAND_WIDTH];
            b_q    <= bus.req_b[int'(grant_idx)*OPERAND_WIDTH +: OPERAND_WIDTH];
            tag_q  <= bus.req_tag[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
            type_q <= sel_type;
            hi_q   <= sel_hi;
            rr_ptr <= rr_next;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.flush) begin
            kill <= 1'b1;
          end
          // The multiplier cannot abort, so a killed op still waits for done.
          if (bus.mul_done) begin
            if (drop) begin
              kill  <= 1'b0;
              state <= IDLE;
            end else begin
              data_q <= hi_q ? bus.mul_p[2*OPERAND_WIDTH-1:OPERAND_WIDTH]
                             : bus.mul_p[OPERAND_WIDTH-1:0];
              state  <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.flush || bus.resp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_data  = data_q;
  assign bus.resp_tag   = tag_q;
  assign bus.busy       = (state != IDLE);
  assign bus.mul_start  = (state == ISSUE);
  assign bus.mul_type   = type_q;
  assign bus.mul_a      = a_q;
  assign bus.mul_b      = b_q;

endmodule

// File: tb/tb_mul_fu_controller.sv
// Directed bench for mul_fu_controller with a behavioural shift-add multiplier
// whose done pulse arrives 2*OPERAND_WIDTH+1 cycles after start is first seen.
module tb_mul_fu_controller;

  localparam int NR  = 2;
  localparam int OW  = 32;
  localparam int TW  = 5;
  localparam int LAT = 2*OW + 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mul_fu_controller_if #(.NUM_REQ(NR), .OPERAND_WIDTH(OW), .TAG_WIDTH(TW)) bus_if ();

  mul_fu_controller #(.NUM_REQ(NR), .OPERAND_WIDTH(OW), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  function automatic logic [2*OW-1:0] ref_product(input logic [1:0] t,
                                                   input logic [OW-1:0] a,
                                                   input logic [OW-1:0] b);
    logic [2*OW-1:0] ea;
    logic [2*OW-1:0] eb;
    ea = (t == 2'd1 || t == 2'd2) ? {{OW{a[OW-1]}}, a} : {{OW{1'b0}}, a};
    eb = (t == 2'd1) ? {{OW{b[OW-1]}}, b} : {{OW{1'b0}}, b};
    return ea * eb;
  endfunction

  logic [1:0]      m_state;
  int              m_cnt;
  logic [2*OW-1:0] m_p;

  always @(posedge clk) begin
    if (rst) begin
      m_state <= 2'd0;
      m_cnt   <= 0;
      m_p     <= '0;
    end else begin
      case (m_state)
        2'd0: if (bus_if.mul_start) begin
          m_state <= 2'd1;
          m_cnt   <= 0;
          m_p     <= ref_product(bus_if.mul_type, bus_if.mul_a, bus_if.mul_b);
        end
        2'd1: if (m_cnt == 2*OW-1) m_state <= 2'd2; else m_cnt <= m_cnt + 1;
        default: m_state <= 2'd0;
      endcase
    end
  end

  assign bus_if.mul_done = (m_state == 2'd2);
  assign bus_if.mul_p    = (m_state == 2'd2) ? m_p : '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " req_ready"},  bus_if.req_ready,  0);
    check({name, " resp_valid"}, bus_if.resp_valid, 0);
    check({name, " resp_data"},  bus_if.resp_data,  0);
    check({name, " resp_tag"},   bus_if.resp_tag,   0);
    check({name, " busy"},       bus_if.busy,       0);
    check({name, " mul_start"},  bus_if.mul_start,  0);
    check({name, " mul_type"},   bus_if.mul_type,   0);
    check({name, " mul_a"},      bus_if.mul_a,      0);
    check({name, " mul_b"},      bus_if.mul_b,      0);
  endtask

  task automatic drive_req(input int idx, input logic [2:0] f3, input logic [OW-1:0] a,
                           input logic [OW-1:0] b, input logic [TW-1:0] tag);
    bus_if.req_funct3[idx*3 +: 3] = f3;
    bus_if.req_a[idx*OW +: OW]    = a;
    bus_if.req_b[idx*OW +: OW]    = b;
    bus_if.req_tag[idx*TW +: TW]  = tag;
    bus_if.req_valid[idx]         = 1'b1;
  endtask

  // Presents a request, waits for its grant and checks the issue cycle.
  task automatic accept(input int idx, input logic [2:0] f3, input logic [OW-1:0] a,
                        input logic [OW-1:0] b, input logic [TW-1:0] tag,
                        input logic [1:0] etype, input string name);
    int w;
    @(negedge clk);
    drive_req(idx, f3, a, b, tag);
    #1;
    w = 0;
    while (bus_if.req_ready[idx] !== 1'b1 && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    check({name, " grant"}, bus_if.req_ready, 64'(1) << idx);
    @(negedge clk);
    bus_if.req_valid[idx] = 1'b0;
    check({name, " mul_start"}, bus_if.mul_start, 1);
    check({name, " mul_type"},  bus_if.mul_type,  etype);
    check({name, " mul_a"},     bus_if.mul_a,     a);
    check({name, " mul_b"},     bus_if.mul_b,     b);
  endtask

  task automatic run_op(input int idx, input logic [2:0] f3, input logic [OW-1:0] a,
                        input logic [OW-1:0] b, input logic [TW-1:0] tag,
                        input logic [1:0] etype, input logic [OW-1:0] edata,
                        input int hold, input bit flush_resp, input string name);
    int lat;
    int other;
    accept(idx, f3, a, b, tag, etype, name);
    lat = 1;
    while (bus_if.resp_valid !== 1'b1 && lat < LAT + 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"},   lat,              LAT);
    check({name, " resp_data"}, bus_if.resp_data, edata);
    check({name, " resp_tag"},  bus_if.resp_tag,  tag);
    other = (idx + 1) % NR;
    for (int k = 0; k < hold; k++) begin
      bus_if.req_valid[other] = 1'b1;
      #1;
      check({name, " hold no grant"}, bus_if.req_ready, 0);
      @(negedge clk);
      check({name, " hold valid"}, bus_if.resp_valid, 1);
      check({name, " hold data"},  bus_if.resp_data,  edata);
    end
    bus_if.req_valid[other] = 1'b0;
    bus_if.flush      = flush_resp;
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    check({name, " valid drop"}, bus_if.resp_valid, 0);
    check({name, " idle"},       bus_if.busy,       0);
    bus_if.flush      = 1'b0;
    bus_if.resp_ready = 1'b0;
  endtask

  task automatic run_flush_issue(input int idx, input logic [2:0] f3, input logic [OW-1:0] a,
                                 input logic [OW-1:0] b, input logic [TW-1:0] tag,
                                 input logic [1:0] etype, input int flush_lat, input string name);
    int lat;
    bit seen;
    accept(idx, f3, a, b, tag, etype, name);
    lat  = 1;
    seen = 1'b0;
    while (bus_if.mul_done !== 1'b1 && lat < LAT + 20) begin
      if (bus_if.resp_valid === 1'b1) seen = 1'b1;
      bus_if.flush = (lat == flush_lat);
      @(negedge clk);
      lat++;
    end
    bus_if.flush = 1'b0;
    check({name, " done cycle"}, lat, LAT - 1);
    check({name, " busy at done"}, bus_if.busy, 1);
    @(negedge clk);
    check({name, " idle after done"}, bus_if.busy,       0);
    check({name, " no resp_valid"},   bus_if.resp_valid, 0);
    check({name, " never valid"},     seen,              0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    int rr_exp[4];
    int ng;
    int nr;
    rr_exp = '{0, 1, 0, 1};

    rst               = 1'b1;
    bus_if.flush      = 1'b0;
    bus_if.req_valid  = '0;
    bus_if.req_funct3 = '0;
    bus_if.req_a      = '0;
    bus_if.req_b      = '0;
    bus_if.req_tag    = '0;
    bus_if.resp_ready = 1'b0;

    // Round-robin: both requesters valid from reset; req0 2*3 tag 10, req1 4*5 tag 11.
    drive_req(0, 3'b000, 32'd2, 32'd3, 5'd10);
    drive_req(1, 3'b000, 32'd4, 32'd5, 5'd11);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    bus_if.resp_ready = 1'b1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 6*LAT && nr < 4; c++) begin
      #1;
      if (bus_if.req_ready !== '0 && ng < 4) begin
        check("rr grant", bus_if.req_ready, 64'(1) << rr_exp[ng]);
        check("rr start gap", bus_if.mul_start, 0);
        ng++;
      end
      if (bus_if.resp_valid === 1'b1) begin
        check("rr data", bus_if.resp_data, (rr_exp[nr] == 0) ? 6 : 20);
        check("rr tag",  bus_if.resp_tag,  (rr_exp[nr] == 0) ? 10 : 11);
        nr++;
        if (nr == 4) bus_if.req_valid = '0;
      end
      @(negedge clk);
    end
    bus_if.req_valid  = '0;
    bus_if.resp_ready = 1'b0;
    check("rr grants",    ng, 4);
    check("rr responses", nr, 4);

    run_op(0, 3'b000, 32'd7,        32'd6,        5'd3,  2'd0, 32'd42,       0, 1'b0, "mul");
    run_op(1, 3'b001, 32'hFFFFFFFD, 32'd5,        5'd4,  2'd1, 32'hFFFFFFFF, 0, 1'b0, "mulh");
    run_op(1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  2'd0, 32'hFFFFFFFE, 0, 1'b0, "mulhu");
    run_op(0, 3'b010, 32'hFFFFFFFF, 32'd2,        5'd6,  2'd2, 32'hFFFFFFFF, 5, 1'b0, "mulhsu");

    // Flush in IDLE blocks the grant.
    @(negedge clk);
    drive_req(0, 3'b000, 32'd1, 32'd1, 5'd1);
    bus_if.flush = 1'b1;
    #1;
    check("idle flush no grant", bus_if.req_ready, 0);
    @(negedge clk);
    check("idle flush no accept", bus_if.busy, 0);
    bus_if.req_valid = '0;
    bus_if.flush     = 1'b0;

    run_flush_issue(1, 3'b000, 32'd9, 32'd9, 5'd8, 2'd0, 20, "flush issue");
    run_op(0, 3'b001, 32'h00010000, 32'h00010000, 5'd9, 2'd1, 32'd1, 0, 1'b0, "post flush");
    run_op(1, 3'b000, 32'd10, 32'd10, 5'd12, 2'd0, 32'd100, 0, 1'b1, "flush resp");

    // Reset in the middle of ISSUE.
    accept(0, 3'b011, 32'h12345678, 32'h9ABCDEF0, 5'd13, 2'd0, "rst issue");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid reset");
    rst = 1'b0;
    run_op(0, 3'b000, 32'd3, 32'd4, 5'd7, 2'd0, 32'd12, 0, 1'b0, "after rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
